// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   EX/MEM pipeline register plus the data-memory access stage of a 5-stage
//   RV64 pipeline. It holds the instruction handed over by execute and
//   performs its load/store over a req/ack data-memory port. It also
//   sign/zero-extends load data and resolves conditional branches. Finally it
//   registers the writeback bundle for the WB stage.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     defined   -> an ack watchdog abandons a WAIT after TIMEOUT_CYCLES cycles.
//                  The op completes with read data 0 and the sticky bus_err_o
//                  port is set.
//     undefined -> no watchdog and no bus_err_o; WAIT lasts until ack.
//
//   Ports
//     clk_i, reset_i          clock, asynchronous active-low reset
//     ex_*/alu_result_i/...   instruction fields and control from execute
//     stall_o                 freeze IF/ID/EX and hold this stage
//     mem_fwd_data_o, rd_x_o, regwrite_x_o
//                             stage-register values forwarded to execute
//     branch_taken_o, branch_pc_o
//                             branch redirect
//     misalign_o              one-cycle pulse: misaligned access dropped
//     dmem_*                  data-memory request port
//     wb_*                    registered writeback bundle
//     bus_err_o               sticky watchdog error (MEM_TIMEOUT_EN only)
//     dbg_state_o             access FSM state (0 IDLE, 1 WAIT)
//
//   Handshake: dmem_req_o is held high, with addr/we/be/wdata stable, from
//   the first cycle of an access until the cycle in which dmem_ack_i is high.
//   That cycle completes the access. An ack seen while dmem_req_o is low has
//   no effect.
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            zero_i,
    input  logic            ltz_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic            regwrite_i,
    input  logic            memread_i,
    input  logic            memwrite_i,
    input  logic            memtoreg_i,
    input  logic            branch_i,
    output logic            stall_o,
    output logic [XLEN-1:0] mem_fwd_data_o,
    output logic [4:0]      rd_x_o,
    output logic            regwrite_x_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] branch_pc_o,
    output logic            misalign_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [7:0]      dmem_be_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_regwrite_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
`ifdef MEM_TIMEOUT_EN
    output logic            bus_err_o,
`endif
    output logic [0:0]      dbg_state_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // ---------------- stage register ----------------
    logic            valid_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] sdata_q;
    logic [XLEN-1:0] target_q;
    logic            zero_q;
    logic            ltz_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            regwrite_q;
    logic            memread_q;
    logic            memwrite_q;
    logic            memtoreg_q;
    logic            branch_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            sdata_q    <= '0;
            target_q   <= '0;
            zero_q     <= 1'b0;
            ltz_q      <= 1'b0;
            funct3_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            branch_q   <= 1'b0;
        end else if (!stall_o) begin
            valid_q    <= ex_valid_i;
            alu_q      <= alu_result_i;
            sdata_q    <= store_data_i;
            target_q   <= branch_target_i;
            zero_q     <= zero_i;
            ltz_q      <= ltz_i;
            funct3_q   <= funct3_i;
            rd_q       <= rd_i;
            regwrite_q <= regwrite_i;
            memread_q  <= memread_i;
            memwrite_q <= memwrite_i;
            memtoreg_q <= memtoreg_i;
            branch_q   <= branch_i;
        end
    end

    // ---------------- access decode ----------------
    logic       aligned;
    logic [7:0] size_mask;
    logic       access;
    logic       mem_op;
    logic       timeout;
    logic       complete;

    always_comb begin
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (funct3_q[1:0])
            2'b00: begin aligned = 1'b1;                size_mask = 8'h01; end
            2'b01: begin aligned = ~alu_q[0];           size_mask = 8'h03; end
            2'b10: begin aligned = (alu_q[1:0] == 2'b0); size_mask = 8'h0F; end
            default: begin aligned = (alu_q[2:0] == 3'b0); size_mask = 8'hFF; end
        endcase
    end

    assign access   = valid_q & (memread_q | memwrite_q);
    assign mem_op   = access & aligned;
    assign complete = mem_op & (dmem_ack_i | timeout);

    assign stall_o    = mem_op & ~dmem_ack_i & ~timeout;
    assign misalign_o = access & ~aligned;

    // Request attributes are only driven while a request is up so the port
    // reads all-zero when idle.
    assign dmem_req_o   = mem_op & ~timeout;
    assign dmem_we_o    = dmem_req_o & memwrite_q;
    assign dmem_addr_o  = dmem_req_o ? alu_q : '0;
    assign dmem_be_o    = dmem_req_o ? (size_mask << alu_q[2:0]) : 8'h00;
    assign dmem_wdata_o = dmem_req_o ? (sdata_q << {alu_q[2:0], 3'b000}) : '0;

    // ---------------- load extraction ----------------
    logic [XLEN-1:0] rdata_eff;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] load_data;

    assign rdata_eff = timeout ? '0 : dmem_rdata_i;
    assign rshift    = rdata_eff >> {alu_q[2:0], 3'b000};

    always_comb begin
        load_data = rshift;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){rshift[7]}},   rshift[7:0]};
            3'b001:  load_data = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            3'b010:  load_data = {{(XLEN-32){rshift[31]}}, rshift[31:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}},        rshift[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}},       rshift[15:0]};
            3'b110:  load_data = {{(XLEN-32){1'b0}},       rshift[31:0]};
            default: load_data = rshift;
        endcase
    end

    // ---------------- branch resolution ----------------
    logic cond;

    always_comb begin
        cond = 1'b0;
        case (funct3_q)
            3'b000:         cond = zero_q;
            3'b001:         cond = ~zero_q;
            3'b100, 3'b110: cond = ltz_q;   // ALU puts the unsigned compare in ltz for 11x
            3'b101, 3'b111: cond = ~ltz_q;
            default:        cond = 1'b0;
        endcase
    end

    assign branch_taken_o = valid_q & branch_q & cond;
    assign branch_pc_o    = target_q;

    // ---------------- forwarding ----------------
    assign mem_fwd_data_o = alu_q;
    assign rd_x_o         = rd_q;
    assign regwrite_x_o   = valid_q & regwrite_q;

    // ---------------- access FSM ----------------
    state_t state_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    // The cycle after TIMEOUT_CYCLES unacknowledged WAIT cycles is the
    // abandon cycle: request down, op completes with zero data.
    assign timeout   = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign bus_err_o = bus_err_q;
`else
    // Watchdog not built; the parameter has no effect in this configuration.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE:  state_q <= stall_o ? S_WAIT : S_IDLE;
                default: state_q <= complete ? S_IDLE : S_WAIT;
            endcase
`ifdef MEM_TIMEOUT_EN
            if (state_q == S_WAIT && stall_o) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if (timeout) begin
                bus_err_q <= 1'b1;
            end
`endif
        end
    end

    assign dbg_state_o = state_q;

    // ---------------- writeback register ----------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wb_valid_o    <= 1'b0;
            wb_regwrite_o <= 1'b0;
            wb_rd_o       <= '0;
            wb_data_o     <= '0;
        end else if (stall_o) begin
            wb_valid_o    <= 1'b0;
            wb_regwrite_o <= 1'b0;
        end else begin
            wb_valid_o    <= valid_q;
            // A dropped misaligned load must not write its destination.
            wb_regwrite_o <= valid_q & regwrite_q & ~(misalign_o & memread_q);
            wb_rd_o       <= rd_q;
            wb_data_o     <= memtoreg_q ? load_data : alu_q;
        end
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- EX/MEM pipeline register plus data-memory access stage of the 5-stage RV64 pipeline; consumes the execute stage's ALU result, store data, zero/ltz flags, funct3 and branch target.
- Drives a req/ack data-memory port, sign/zero-extends loads, resolves conditional branches, and produces the MEM-stage forwarding value, rd and regwrite back to execute.
- Registers the writeback bundle for the WB stage.

Parameters:
- XLEN, 64, datapath width.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- ex_valid_i  in  1  execute stage holds a valid instruction
- alu_result_i  in  XLEN  ALU result / effective address
- store_data_i  in  XLEN  forwarded rs2 value
- zero_i, ltz_i  in  1  ALU flags
- branch_target_i  in  XLEN  PC+imm from branch adder
- funct3_i  in  3  instruction funct3
- rd_i  in  5  destination register
- regwrite_i, memread_i, memwrite_i, memtoreg_i, branch_i  in  1  control bits
- stall_o  out  1  freeze IF/ID/EX and hold this stage
- mem_fwd_data_o  out  XLEN  stage-register ALU result (execute MemAddr forward input)
- rd_x_o  out  5  stage-register rd
- regwrite_x_o  out  1  stage valid & regwrite
- branch_taken_o  out  1  taken branch in stage
- branch_pc_o  out  XLEN  redirect target
- misalign_o  out  1  one-cycle pulse, misaligned access dropped
- dmem_req_o, dmem_we_o  out  1  memory request / write
- dmem_addr_o  out  XLEN  address (alu_result, byte address)
- dmem_wdata_o  out  XLEN  lane-shifted store data
- dmem_be_o  out  8  byte enables
- dmem_ack_i  in  1  request complete
- dmem_rdata_i  in  XLEN  aligned 64-bit read word
- wb_valid_o, wb_regwrite_o  out  1  WB bundle valid / write enable
- wb_rd_o  out  5  WB destination
- wb_data_o  out  XLEN  load data if memtoreg else ALU result

Behaviour:
- Reset (reset_i=0, async): stage valid=0, FSM=IDLE, every output 0. Reset during an outstanding access: dmem_req_o drops immediately; transaction abandoned, any later ack ignored.
- Stage register loads all ex_* inputs on the rising edge when stall_o=0; holds when stall_o=1.
- mem op = valid & (memread|memwrite) & aligned. Aligned: funct3[1:0]=00 any; 01 addr[0]=0; 10 addr[1:0]=0; 11 addr[2:0]=0.
- FSM IDLE/WAIT:
  - IDLE with mem op: req=1 combinationally. If ack is in the same cycle, the op completes (zero-wait). Otherwise go to WAIT.
  - WAIT: hold req/addr/we/be/wdata stable until ack, then complete and return to IDLE.
  - Ack while req=0 is ignored.
- stall_o = mem op & ~dmem_ack_i (combinational).
- Store byte enables: size 1/2/4/8 bytes per funct3[1:0], shifted left by addr[2:0]. wdata = store_data << 8*addr[2:0].
- Load extract: select bytes at addr[2:0] from rdata. funct3 000 LB, 001 LH, 010 LW, 011 LD sign-extend; 100 LBU, 101 LHU, 110 LWU zero-extend.
- Misaligned access:
  - no request is issued and misalign_o pulses.
  - wb_regwrite is forced 0 for loads.
  - The instruction retires as a bubble without stalling.
- Branch, combinational from the stage register: taken = valid & branch & cond, where cond is selected by funct3:
  - 000 zero
  - 001 ~zero
  - 100/110 ltz
  - 101/111 ~ltz (ALU supplies the unsigned compare in ltz for 11x)
  - branch_pc_o = stage branch_target. Branches never stall.
- WB registers:
  - Update every edge. On a completing cycle: wb_valid_o=1 with the bundle. While stall_o=1: wb_valid_o=0 and wb_regwrite_o=0 (bubble).
  - Latency: non-mem op reaches WB one cycle after entering the stage. A load reaches WB on the edge its ack is sampled.
- Forward outputs are always the stage-register values; regwrite_x_o=0 when the stage is invalid.

Optional Feature:
- MEM_TIMEOUT_EN defined: an 8-bit-wide counter (sized by $clog2(TIMEOUT_CYCLES+1)) counts cycles in WAIT. On reaching TIMEOUT_CYCLES:
  - req drops and the op completes as if acked, with rdata=0.
  - Sticky output bus_err_o (added port) is set; it clears only on reset.
- Undefined: no counter and no bus_err_o port; WAIT persists indefinitely.

Test Plan:
- ADD (regwrite, rd=5, alu=0x1234), no mem op -> next cycle mem_fwd_data_o=0x1234, rd_x_o=5, regwrite_x_o=1; following edge wb_valid_o=1, wb_data_o=0x1234.
- LW at 0x1004, ack after 3 cycles, rdata=0x80000000_00000000 -> stall_o high 3 cycles, dmem_req_o stable; wb_data_o=0xFFFFFFFF_80000000; LWU gives 0x00000000_80000000.
- SH at 0x1006, store_data=0xBEEF, zero-wait ack -> dmem_be_o=0xC0, dmem_wdata_o=0xBEEF<<48, no stall.
- BNE with zero_i=0, target 0x2000 -> branch_taken_o=1, branch_pc_o=0x2000; with zero_i=1 -> 0.
- LD at 0x1004 -> misalign_o pulse, dmem_req_o=0, wb_regwrite_o=0; reset_i low during WAIT -> req drops same cycle, all outputs 0.
- (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4) load with no ack -> req drops after 4 WAIT cycles, bus_err_o=1, wb_data_o=0.
